rr_packet_switch: RTL and testbench
===================================

Name: rr_packet_switch

Overview:
- Downstream consumer of the round-robin arbiter's registered one-hot grant.
- Presents requester valids to the arbiter and pulses its enable once per arbitration.
- After a grant, locks onto the winning requester and forwards its multi-beat packet to a single shared valid/ready output.
- Returns to arbitration at end of packet or when the beat limit is reached.

Parameters:
- N, 8: number of requesters; must match the arbiter's N.
- DW, 32: data width per beat.
- MAX_BEATS, 16: maximum beats per grant, must be ≥1. On reaching it the packet is cut and the channel is released.
- M, $clog2(N) (localparam): width of the source index.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_valid  in  N  per-requester beat valid.
- i_data  in  N*DW  per-requester beat data, flattened; requester k occupies bits [k*DW +: DW].
- i_last  in  N  per-requester end-of-packet marker, qualified by i_valid.
- o_ready  out  N  per-requester ready; at most one bit set.
- o_arb_req  out  N  request vector to the arbiter; equals i_valid.
- o_arb_en  out  1  arbitration enable to the arbiter.
- i_gnt  in  N  registered grant from the arbiter; valid one cycle after o_arb_en.
- o_valid  out  1  shared output valid.
- o_data  out  DW  shared output data.
- o_last  out  1  shared output end-of-packet.
- o_src  out  M  index of the requester currently owning the output.
- i_ready  in  1  downstream ready.
- o_trunc  out  1  one-cycle pulse when a packet is cut at MAX_BEATS.
- o_gnt_err  out  1  one-cycle pulse when the grant is not one-hot and non-zero.
- o_busy  out  1  high while in GNT or XFER.

Behaviour:
- Reset (async assert, sync release):
  - state=ARB, sel=0, beat_cnt=0.
  - o_ready, o_valid, o_data, o_last, o_src, o_trunc, o_gnt_err, o_busy, o_arb_en all 0.
- o_arb_req=i_valid at all times, combinational.
- Three-state FSM:
  - ARB:
    - o_arb_en = |i_valid, combinational.
    - If o_arb_en=1, go to GNT next cycle; otherwise stay in ARB.
  - GNT (one cycle; i_gnt now reflects the arbitration of the previous edge):
    - i_gnt==0 (requests withdrawn) -> ARB.
    - i_gnt one-hot -> sel=index of the set bit, beat_cnt=0, go to XFER.
    - Any other value -> o_gnt_err pulses next cycle, go to ARB; no transfer.
  - XFER:
    - Combinational pass-through, zero latency: o_valid=i_valid[sel], o_data=i_data[sel], o_ready[sel]=i_ready, other o_ready bits 0, o_src=sel.
    - Beat fires when o_valid && i_ready.
    - o_last = i_last[sel] | (beat_cnt==MAX_BEATS-1).
    - On a fired beat with o_last=1 -> ARB. o_trunc pulses the next cycle if i_last[sel]=0 (forced cut); the requester resumes its packet on a later grant.
    - On a fired beat with o_last=0 -> beat_cnt+1.
    - No beat fired -> hold state and beat_cnt.
    - An idle owner stalls the channel indefinitely; there is no timeout.
- Outside XFER: o_valid=0, o_data=0, o_last=0, o_ready=0; o_src holds its last value.
- beat_cnt is $clog2(MAX_BEATS+1) bits wide and never wraps.
- MAX_BEATS=1: every beat is cut and re-arbitrated. o_trunc pulses unless i_last=1.
- Grant-to-first-beat latency:
  - Edge after ARB with o_arb_en=1 -> GNT.
  - Next edge -> XFER.
  - First beat can fire 2 cycles after o_arb_en.
- Minimum gap between packets: 2 dead cycles (ARB, GNT).
- Upstream must hold i_data/i_last stable while i_valid=1 and o_ready=0.
- Reset asserted mid-packet aborts immediately: all outputs 0, state ARB, no o_trunc pulse.

Test Plan:
(N=4, DW=8, MAX_BEATS=4)
- Req 2 only, 3-beat packet A0,A1,A2 (last on A2), i_ready=1:
  - o_arb_en=1 in cycle 0; i_gnt=0100 in cycle 1.
  - o_src=2, o_data A0,A1,A2 in cycles 2-4; o_last only on A2.
  - o_arb_en again in cycle 5 if valid remains.
- Req 0 and 3 both valid, 1-beat packets, arbiter grants 0 then 3:
  - Output order src 0 then src 3; each grant separated by ARB/GNT cycles.
  - o_ready=0001 during the first packet, then 1000.
- Req 1 sends 6 beats with no last:
  - Beats 0-3 forwarded; o_last forced on beat 3; o_trunc pulses once.
  - After re-grant, beats 4-5 forwarded with o_last on beat 5; no second o_trunc.
- Backpressure: i_ready low for 3 cycles mid-packet:
  - o_valid held, o_data stable, beat_cnt unchanged; no beat lost or duplicated.
- i_gnt=0110 in GNT:
  - o_gnt_err=1 for one cycle; no o_valid; FSM back in ARB.
  - i_gnt=0000 in GNT: no error, return to ARB.
- i_rstn asserted during beat 2 of a packet:
  - All outputs 0 immediately.
  - After release, o_arb_en asserts only when i_valid is set; no o_trunc pulse.

Source files
------------

// File: rtl/rr_packet_switch.sv
// rr_packet_switch: locks the shared output onto the arbiter's winner
// and forwards its multi-beat packet, releasing at last or MAX_BEATS.
// Ports: i_valid/i_data/i_last/o_ready per requester; o_arb_req/o_arb_en
// to the arbiter, i_gnt back; o_valid/o_data/o_last/o_src/i_ready shared
// output; o_trunc/o_gnt_err one-cycle pulses; o_busy in GNT or XFER.
module rr_packet_switch #(
    parameter int N         = 8,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16,
    localparam int M        = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [N-1:0]    i_valid,
    input  logic [N*DW-1:0] i_data,
    input  logic [N-1:0]    i_last,
    output logic [N-1:0]    o_ready,
    output logic [N-1:0]    o_arb_req,
    output logic            o_arb_en,
    input  logic [N-1:0]    i_gnt,
    output logic            o_valid,
    output logic [DW-1:0]   o_data,
    output logic            o_last,
    output logic [M-1:0]    o_src,
    input  logic            i_ready,
    output logic            o_trunc,
    output logic            o_gnt_err,
    output logic            o_busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        GNT  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [M-1:0]  sel, sel_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic          trunc_n, gnt_err_n;
    logic          gnt_onehot;
    logic [M-1:0]  gnt_idx;
    logic          fire;

    assign o_arb_req = i_valid;
    assign o_src     = sel;
    assign o_busy    = (state != ARB);

    // Power-of-two test: exactly one bit set.
    assign gnt_onehot = (i_gnt != '0) && ((i_gnt & (i_gnt - 1'b1)) == '0);

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (i_gnt[k]) gnt_idx = M'(k);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ARB;
            sel       <= '0;
            beat_cnt  <= '0;
            o_trunc   <= 1'b0;
            o_gnt_err <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            beat_cnt  <= beat_cnt_n;
            o_trunc   <= trunc_n;
            o_gnt_err <= gnt_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        beat_cnt_n = beat_cnt;
        trunc_n    = 1'b0;
        gnt_err_n  = 1'b0;
        o_arb_en   = 1'b0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_last     = 1'b0;
        o_ready    = '0;
        fire       = 1'b0;
        unique case (state)
            ARB: begin
                // Gated so the arbiter sees no enable while held in reset.
                o_arb_en = i_rstn && (|i_valid);
                if (o_arb_en) state_n = GNT;
            end
            GNT: begin
                if (i_gnt == '0) begin
                    state_n = ARB;
                end else if (gnt_onehot) begin
                    sel_n      = gnt_idx;
                    beat_cnt_n = '0;
                    state_n    = XFER;
                end else begin
                    gnt_err_n = 1'b1;
                    state_n   = ARB;
                end
            end
            XFER: begin
                o_valid      = i_valid[sel];
                o_data       = i_data[sel*DW +: DW];
                o_ready[sel] = i_ready;
                o_last       = i_last[sel] |
                               (beat_cnt == CW'(MAX_BEATS - 1));
                fire         = o_valid && i_ready;
                if (fire) begin
                    if (o_last) begin
                        state_n = ARB;
                        trunc_n = !i_last[sel];
                    end else begin
                        beat_cnt_n = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

endmodule

// File: tb/tb_rr_packet_switch.sv
// tb_rr_packet_switch: directed vectors for rr_packet_switch with N=4,
// DW=8, MAX_BEATS=4; the bench plays the arbiter by driving i_gnt.
module tb_rr_packet_switch;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int M  = 2;

    logic            i_clk = 1'b0;
    logic            i_rstn;
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_last;
    logic [N-1:0]    o_ready;
    logic [N-1:0]    o_arb_req;
    logic            o_arb_en;
    logic [N-1:0]    i_gnt;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [M-1:0]    o_src;
    logic            i_ready;
    logic            o_trunc;
    logic            o_gnt_err;
    logic            o_busy;

    int total = 0;
    int bad   = 0;

    rr_packet_switch #(.N(N), .DW(DW), .MAX_BEATS(MB)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .o_ready(o_ready), .o_arb_req(o_arb_req), .o_arb_en(o_arb_en),
        .i_gnt(i_gnt), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .o_src(o_src), .i_ready(i_ready),
        .o_trunc(o_trunc), .o_gnt_err(o_gnt_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic put(input int k, input logic [DW-1:0] d,
                       input logic l);
        i_data[k*DW +: DW] = d;
        i_last[k]          = l;
    endtask

    task automatic out(input string tag, input logic v,
                       input logic [DW-1:0] d, input logic l,
                       input logic [N-1:0] r);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".data"}, 32'(o_data), 32'(d));
        chk({tag, ".last"}, 32'(o_last), 32'(l));
        chk({tag, ".ready"}, 32'(o_ready), 32'(r));
    endtask

    initial begin
        i_rstn  = 1'b0;
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        i_gnt   = '0;
        i_ready = 1'b1;
        #1;
        // reset state
        out("rst", 0, 8'h00, 0, 4'b0000);
        chk("rst.src", 32'(o_src), 0);
        chk("rst.busy", 32'(o_busy), 0);
        chk("rst.arb_en", 32'(o_arb_en), 0);
        chk("rst.trunc", 32'(o_trunc), 0);
        chk("rst.gnt_err", 32'(o_gnt_err), 0);
        tick();
        i_rstn = 1'b1;

        // req 2 alone, 3 beats
        i_valid = 4'b0100;
        put(2, 8'hA0, 0);
        #1;
        chk("t1.arb_req", 32'(o_arb_req), 32'h4);
        chk("t1.arb_en", 32'(o_arb_en), 1);
        chk("t1.busy0", 32'(o_busy), 0);
        tick();
        i_gnt = 4'b0100;
        #1;
        chk("t1.gnt_busy", 32'(o_busy), 1);
        chk("t1.gnt_arb_en", 32'(o_arb_en), 0);
        out("t1.gnt", 0, 8'h00, 0, 4'b0000);
        tick();
        i_gnt = '0;
        out("t1.b0", 1, 8'hA0, 0, 4'b0100);
        chk("t1.src", 32'(o_src), 2);
        tick();
        put(2, 8'hA1, 0);
        #1;
        out("t1.b1", 1, 8'hA1, 0, 4'b0100);
        tick();
        put(2, 8'hA2, 1);
        #1;
        out("t1.b2", 1, 8'hA2, 1, 4'b0100);
        tick();
        out("t1.done", 0, 8'h00, 0, 4'b0000);
        chk("t1.src_hold", 32'(o_src), 2);
        chk("t1.trunc", 32'(o_trunc), 0);
        chk("t1.rearb", 32'(o_arb_en), 1);
        i_valid = '0;
        #1;
        chk("t1.idle", 32'(o_arb_en), 0);
        tick();

        // req 0 and 3, single-beat packets
        i_valid = 4'b1001;
        put(0, 8'h10, 1);
        put(3, 8'h30, 1);
        #1;
        chk("t2.arb_en0", 32'(o_arb_en), 1);
        tick();
        i_gnt = 4'b0001;
        tick();
        i_gnt = '0;
        out("t2.p0", 1, 8'h10, 1, 4'b0001);
        chk("t2.src0", 32'(o_src), 0);
        tick();
        i_valid = 4'b1000;
        #1;
        out("t2.gap", 0, 8'h00, 0, 4'b0000);
        chk("t2.arb_en1", 32'(o_arb_en), 1);
        tick();
        i_gnt = 4'b1000;
        tick();
        i_gnt = '0;
        out("t2.p3", 1, 8'h30, 1, 4'b1000);
        chk("t2.src3", 32'(o_src), 3);
        tick();
        i_valid = '0;
        i_last  = '0;
        tick();

        // req 1, 6 beats without last: cut at 4
        i_valid = 4'b0010;
        put(1, 8'h40, 0);
        tick();
        i_gnt = 4'b0010;
        tick();
        i_gnt = '0;
        for (int b = 0; b < 4; b++) begin
            put(1, 8'(8'h40 + b), 0);
            #1;
            out($sformatf("t3.b%0d", b), 1, 8'(8'h40 + b), b == 3,
                4'b0010);
            chk($sformatf("t3.tr%0d", b), 32'(o_trunc), 0);
            tick();
        end
        put(1, 8'h44, 0);
        #1;
        chk("t3.trunc", 32'(o_trunc), 1);
        chk("t3.arb_en", 32'(o_arb_en), 1);
        tick();
        chk("t3.trunc_once", 32'(o_trunc), 0);
        i_gnt = 4'b0010;
        tick();
        i_gnt = '0;
        out("t3.b4", 1, 8'h44, 0, 4'b0010);
        tick();
        put(1, 8'h45, 1);
        #1;
        out("t3.b5", 1, 8'h45, 1, 4'b0010);
        tick();
        chk("t3.no_trunc", 32'(o_trunc), 0);
        i_valid = '0;
        i_last  = '0;
        tick();

        // backpressure on req 2
        i_valid = 4'b0100;
        put(2, 8'h50, 0);
        tick();
        i_gnt = 4'b0100;
        tick();
        i_gnt = '0;
        out("t4.b0", 1, 8'h50, 0, 4'b0100);
        tick();
        put(2, 8'h51, 0);
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            out($sformatf("t4.stall%0d", s), 1, 8'h51, 0, 4'b0000);
            tick();
        end
        i_ready = 1'b1;
        #1;
        out("t4.b1", 1, 8'h51, 0, 4'b0100);
        tick();
        put(2, 8'h52, 0);
        #1;
        out("t4.b2", 1, 8'h52, 0, 4'b0100);
        tick();
        put(2, 8'h53, 0);
        #1;
        out("t4.b3cut", 1, 8'h53, 1, 4'b0100);
        tick();
        chk("t4.trunc", 32'(o_trunc), 1);
        i_valid = '0;
        i_last  = '0;
        tick();

        // bad grant then withdrawn grant
        i_valid = 4'b0110;
        #1;
        chk("t5.arb_en", 32'(o_arb_en), 1);
        tick();
        i_gnt = 4'b0110;
        #1;
        chk("t5.err_pre", 32'(o_gnt_err), 0);
        tick();
        i_gnt = '0;
        chk("t5.err", 32'(o_gnt_err), 1);
        chk("t5.busy", 32'(o_busy), 0);
        out("t5.nov", 0, 8'h00, 0, 4'b0000);
        tick();
        chk("t5.err_once", 32'(o_gnt_err), 0);
        chk("t5.gnt_state", 32'(o_busy), 1);
        i_gnt = 4'b0000;
        tick();
        chk("t5.zero_err", 32'(o_gnt_err), 0);
        chk("t5.zero_busy", 32'(o_busy), 0);
        out("t5.zero_nov", 0, 8'h00, 0, 4'b0000);
        i_valid = '0;
        tick();

        // reset during beat 2
        i_valid = 4'b0100;
        put(2, 8'h60, 0);
        tick();
        i_gnt = 4'b0100;
        tick();
        i_gnt = '0;
        tick();
        put(2, 8'h61, 0);
        tick();
        put(2, 8'h62, 0);
        #1;
        out("t6.b2", 1, 8'h62, 0, 4'b0100);
        i_rstn = 1'b0;
        #1;
        out("t6.rst", 0, 8'h00, 0, 4'b0000);
        chk("t6.rst_busy", 32'(o_busy), 0);
        chk("t6.rst_arb_en", 32'(o_arb_en), 0);
        chk("t6.rst_src", 32'(o_src), 0);
        tick();
        i_valid = '0;
        i_rstn  = 1'b1;
        #1;
        chk("t6.rel_arb_en", 32'(o_arb_en), 0);
        chk("t6.rel_trunc", 32'(o_trunc), 0);
        tick();
        chk("t6.post_trunc", 32'(o_trunc), 0);
        chk("t6.post_arb_en", 32'(o_arb_en), 0);
        i_valid = 4'b0100;
        #1;
        chk("t6.arb_en", 32'(o_arb_en), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
